// File: rtl/call_return_ctrl.sv
// Saves and restores 16-bit return addresses on an 8-bit LIFO stack (push low/high, pop high/low).
// Latency: DONE three cycles after an accepted CALL/RET, one cycle after a rejected request.
// Backpressure: requests are sampled only in IDLE; anything presented while BUSY is dropped.
module call_return_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PC_WIDTH   = 16,
    parameter int DEPTH      = 3
) (
    input  logic                  CLK,
    input  logic                  nRST,
    input  logic                  CALL_REQ,
    input  logic                  RET_REQ,
    input  logic [PC_WIDTH-1:0]   RET_ADDR_IN,
    input  logic                  CLR_ERR,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [PC_WIDTH-1:0]   PC_OUT,
    output logic                  PC_VALID,
    output logic                  OVF_ERR,
    output logic                  UNF_ERR,
    output logic [DEPTH:0]        LEVEL,
    output logic [DATA_WIDTH-1:0] STK_DIN,
    output logic                  STK_nRW,
    output logic                  STK_CE,
    input  logic [DATA_WIDTH-1:0] STK_DOUT,
    input  logic                  STK_FULL,
    input  logic                  STK_EMPTY
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        PUSH_LO = 3'd1,
        PUSH_HI = 3'd2,
        POP_HI  = 3'd3,
        POP_LO  = 3'd4,
        FIN     = 3'd5
    } state_t;

    // A CALL needs room for two bytes, a RET needs two bytes present.
    localparam logic [DEPTH:0] ONE      = (DEPTH+1)'(1);
    localparam logic [DEPTH:0] TWO      = (DEPTH+1)'(2);
    localparam logic [DEPTH:0] CALL_MAX = (DEPTH+1)'((2**DEPTH) - 2);

    state_t                state;
    // Only the high byte must survive past the accept edge; the low byte goes straight to STK_DIN.
    logic [DATA_WIDTH-1:0] addr_hi;

    // Single FSM: state, occupancy, error flags and all outputs are registered together.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state    <= IDLE;
            addr_hi  <= '0;
            LEVEL    <= '0;
            PC_OUT   <= '0;
            BUSY     <= 1'b0;
            DONE     <= 1'b0;
            PC_VALID <= 1'b0;
            OVF_ERR  <= 1'b0;
            UNF_ERR  <= 1'b0;
            STK_CE   <= 1'b0;
            STK_nRW  <= 1'b0;
            STK_DIN  <= '0;
        end else begin
            DONE     <= 1'b0;
            PC_VALID <= 1'b0;
            STK_CE   <= 1'b0;
            STK_nRW  <= 1'b0;
            STK_DIN  <= '0;
            // Clear first so a same-edge set below takes precedence.
            if (CLR_ERR) begin
                OVF_ERR <= 1'b0;
                UNF_ERR <= 1'b0;
            end
            case (state)
                IDLE: begin
                    if (CALL_REQ) begin
                        BUSY <= 1'b1;
                        if (LEVEL <= CALL_MAX && !STK_FULL) begin
                            addr_hi <= RET_ADDR_IN[PC_WIDTH-1:DATA_WIDTH];
                            STK_CE  <= 1'b1;
                            STK_nRW <= 1'b1;
                            STK_DIN <= RET_ADDR_IN[DATA_WIDTH-1:0];
                            state   <= PUSH_LO;
                        end else begin
                            OVF_ERR <= 1'b1;
                            DONE    <= 1'b1;
                            state   <= FIN;
                        end
                    end else if (RET_REQ) begin
                        BUSY <= 1'b1;
                        if (LEVEL >= TWO && !STK_EMPTY) begin
                            STK_CE <= 1'b1;
                            state  <= POP_HI;
                        end else begin
                            UNF_ERR <= 1'b1;
                            DONE    <= 1'b1;
                            state   <= FIN;
                        end
                    end
                end
                PUSH_LO: begin
                    LEVEL   <= LEVEL + ONE;
                    STK_CE  <= 1'b1;
                    STK_nRW <= 1'b1;
                    STK_DIN <= addr_hi;
                    state   <= PUSH_HI;
                end
                PUSH_HI: begin
                    LEVEL <= LEVEL + ONE;
                    DONE  <= 1'b1;
                    state <= FIN;
                end
                POP_HI: begin
                    // The stack pops on this edge; STK_DOUT still shows the pre-pop top.
                    PC_OUT[PC_WIDTH-1:DATA_WIDTH] <= STK_DOUT;
                    LEVEL  <= LEVEL - ONE;
                    STK_CE <= 1'b1;
                    state  <= POP_LO;
                end
                POP_LO: begin
                    PC_OUT[DATA_WIDTH-1:0] <= STK_DOUT;
                    LEVEL    <= LEVEL - ONE;
                    DONE     <= 1'b1;
                    PC_VALID <= 1'b1;
                    state    <= FIN;
                end
                FIN: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    BUSY  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_call_return_ctrl.sv
// Directed bench for call_return_ctrl with a behavioural 8-deep byte LIFO attached.
// Inputs driven and outputs sampled on the falling clock edge.
// Each request ends with one idle cycle before the next is presented.
module tb_call_return_ctrl;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        CALL_REQ = 1'b0;
    logic        RET_REQ = 1'b0;
    logic [15:0] RET_ADDR_IN = 16'h0000;
    logic        CLR_ERR = 1'b0;
    logic        BUSY, DONE, PC_VALID, OVF_ERR, UNF_ERR;
    logic [15:0] PC_OUT;
    logic [3:0]  LEVEL;
    logic [7:0]  STK_DIN, STK_DOUT;
    logic        STK_nRW, STK_CE, STK_FULL, STK_EMPTY;

    int pass_cnt = 0;
    int fail_cnt = 0;
    int total    = 0;

    always #5 CLK = ~CLK;

    call_return_ctrl #(.DATA_WIDTH(8), .PC_WIDTH(16), .DEPTH(3)) dut (
        .CLK(CLK), .nRST(nRST), .CALL_REQ(CALL_REQ), .RET_REQ(RET_REQ),
        .RET_ADDR_IN(RET_ADDR_IN), .CLR_ERR(CLR_ERR), .BUSY(BUSY), .DONE(DONE),
        .PC_OUT(PC_OUT), .PC_VALID(PC_VALID), .OVF_ERR(OVF_ERR), .UNF_ERR(UNF_ERR),
        .LEVEL(LEVEL), .STK_DIN(STK_DIN), .STK_nRW(STK_nRW), .STK_CE(STK_CE),
        .STK_DOUT(STK_DOUT), .STK_FULL(STK_FULL), .STK_EMPTY(STK_EMPTY)
    );

    // Behavioural stack: 8 bytes, combinational top-of-stack, shared reset.
    logic [7:0] mem [8];
    logic [3:0] sp;
    logic [2:0] top_idx;
    assign top_idx   = 3'(sp - 4'd1);
    assign STK_DOUT  = (sp == 4'd0) ? 8'h00 : mem[top_idx];
    assign STK_FULL  = (sp == 4'd8);
    assign STK_EMPTY = (sp == 4'd0);

    always @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            sp <= 4'd0;
        end else if (STK_CE) begin
            if (STK_nRW) begin
                if (sp < 4'd8) begin
                    mem[sp[2:0]] <= STK_DIN;
                    sp <= sp + 4'd1;
                end
            end else if (sp > 4'd0) begin
                sp <= sp - 4'd1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total = total + 1;
        assert (obs === exp) begin
            pass_cnt = pass_cnt + 1;
        end else begin
            fail_cnt = fail_cnt + 1;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Successful CALL; entered and left at a falling edge with the DUT idle.
    task automatic do_call(input logic [15:0] a, input logic [3:0] exp_lvl);
        CALL_REQ = 1'b1; RET_ADDR_IN = a;
        @(negedge CLK);
        CALL_REQ = 1'b0;
        chk("call_ce1", STK_CE, 1);
        chk("call_rw1", STK_nRW, 1);
        chk("call_din_lo", STK_DIN, a[7:0]);
        chk("call_busy", BUSY, 1);
        @(negedge CLK);
        chk("call_ce2", STK_CE, 1);
        chk("call_din_hi", STK_DIN, a[15:8]);
        @(negedge CLK);
        chk("call_done", DONE, 1);
        chk("call_pcv", PC_VALID, 0);
        chk("call_ce3", STK_CE, 0);
        chk("call_level", LEVEL, exp_lvl);
        @(negedge CLK);
        chk("call_done_end", DONE, 0);
        chk("call_idle", BUSY, 0);
    endtask

    // Successful RET.
    task automatic do_ret(input logic [15:0] exp_pc, input logic [3:0] exp_lvl);
        RET_REQ = 1'b1;
        @(negedge CLK);
        RET_REQ = 1'b0;
        chk("ret_ce1", STK_CE, 1);
        chk("ret_rw1", STK_nRW, 0);
        @(negedge CLK);
        chk("ret_ce2", STK_CE, 1);
        chk("ret_rw2", STK_nRW, 0);
        @(negedge CLK);
        chk("ret_done", DONE, 1);
        chk("ret_pcv", PC_VALID, 1);
        chk("ret_pc", PC_OUT, exp_pc);
        chk("ret_level", LEVEL, exp_lvl);
        @(negedge CLK);
        chk("ret_pcv_end", PC_VALID, 0);
        chk("ret_idle", BUSY, 0);
    endtask

    initial begin
        // Reset values
        @(negedge CLK);
        @(negedge CLK);
        chk("rst_busy", BUSY, 0);
        chk("rst_done", DONE, 0);
        chk("rst_level", LEVEL, 0);
        chk("rst_pc", PC_OUT, 0);
        chk("rst_ce", STK_CE, 0);
        chk("rst_rw", STK_nRW, 0);
        chk("rst_din", STK_DIN, 0);
        chk("rst_ovf", OVF_ERR, 0);
        chk("rst_unf", UNF_ERR, 0);
        nRST = 1'b1;
        @(negedge CLK);

        // RET on empty stack, with CLR_ERR on the same edge: set wins
        RET_REQ = 1'b1; CLR_ERR = 1'b1;
        @(negedge CLK);
        RET_REQ = 1'b0; CLR_ERR = 1'b0;
        chk("unf_done", DONE, 1);
        chk("unf_flag", UNF_ERR, 1);
        chk("unf_ce", STK_CE, 0);
        chk("unf_pcv", PC_VALID, 0);
        chk("unf_pc", PC_OUT, 16'h0000);
        @(negedge CLK);
        chk("unf_sticky", UNF_ERR, 1);
        chk("unf_ce_idle", STK_CE, 0);
        chk("unf_sp", sp, 0);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        chk("unf_clear", UNF_ERR, 0);

        // Single CALL, then nested CALL/RET
        do_call(16'h1234, 4'd2);
        do_call(16'hABCD, 4'd4);
        do_ret(16'hABCD, 4'd2);
        do_ret(16'h1234, 4'd0);

        // Fill the stack, then overflow
        do_call(16'h0001, 4'd2);
        do_call(16'h0002, 4'd4);
        do_call(16'h0003, 4'd6);
        do_call(16'h0004, 4'd8);
        CALL_REQ = 1'b1; RET_ADDR_IN = 16'h0005;
        @(negedge CLK);
        CALL_REQ = 1'b0;
        chk("ovf_done", DONE, 1);
        chk("ovf_flag", OVF_ERR, 1);
        chk("ovf_ce", STK_CE, 0);
        chk("ovf_level", LEVEL, 8);
        @(negedge CLK);
        chk("ovf_sp", sp, 8);
        do_ret(16'h0004, 4'd6);
        chk("ovf_sticky", OVF_ERR, 1);
        CLR_ERR = 1'b1;
        @(negedge CLK);
        CLR_ERR = 1'b0;
        chk("ovf_clear", OVF_ERR, 0);
        do_ret(16'h0003, 4'd4);
        do_ret(16'h0002, 4'd2);

        // Simultaneous CALL+RET at LEVEL=2: CALL wins; requests while busy ignored
        CALL_REQ = 1'b1; RET_REQ = 1'b1; RET_ADDR_IN = 16'h0BEE;
        @(negedge CLK);
        chk("both_rw", STK_nRW, 1);
        chk("both_din_lo", STK_DIN, 8'hEE);
        RET_ADDR_IN = 16'h7777;
        @(negedge CLK);
        CALL_REQ = 1'b0; RET_REQ = 1'b0;
        chk("both_rw2", STK_nRW, 1);
        chk("both_din_hi", STK_DIN, 8'h0B);
        @(negedge CLK);
        chk("both_done", DONE, 1);
        chk("both_level", LEVEL, 4);
        @(negedge CLK);
        chk("both_idle", BUSY, 0);
        chk("both_level_idle", LEVEL, 4);
        chk("both_ce_idle", STK_CE, 0);
        do_ret(16'h0BEE, 4'd2);

        // Asynchronous reset during PUSH_HI
        CALL_REQ = 1'b1; RET_ADDR_IN = 16'h5555;
        @(negedge CLK);
        CALL_REQ = 1'b0;
        @(negedge CLK);
        chk("mid_in_push_hi", STK_DIN, 8'h55);
        nRST = 1'b0;
        #1;
        chk("mid_busy", BUSY, 0);
        chk("mid_level", LEVEL, 0);
        chk("mid_ce", STK_CE, 0);
        chk("mid_rw", STK_nRW, 0);
        chk("mid_din", STK_DIN, 0);
        chk("mid_pc", PC_OUT, 0);
        chk("mid_done", DONE, 0);
        @(negedge CLK);
        nRST = 1'b1;
        @(negedge CLK);
        chk("mid_still_idle", BUSY, 0);
        RET_REQ = 1'b1;
        @(negedge CLK);
        RET_REQ = 1'b0;
        chk("post_rst_unf", UNF_ERR, 1);
        chk("post_rst_done", DONE, 1);
        chk("post_rst_ce", STK_CE, 0);
        @(negedge CLK);

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

endmodule
